// File: rtl/ascon_host_ctrl_pkg.sv
// Shared types and constants for the ASCON host-side sequencer.
package ascon_pack;

    localparam int unsigned HOST_NB_BLOCKS      = 4;
    localparam int unsigned HOST_INIT_WAIT      = 18;
    localparam int unsigned HOST_BLOCK_WAIT     = 10;
    localparam int unsigned HOST_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        HOST_IDLE,
        HOST_START,
        HOST_AD,
        HOST_AD_WAIT,
        HOST_PT,
        HOST_PT_WAIT,
        HOST_END_WAIT
    } host_state_t;

    // Four 64-bit plaintext words, index 0 is sent first.
    typedef logic [3:0][63:0] pt_buf_t;

endpackage

// File: rtl/ascon_host_ctrl_if.sv
// Engine-side bundle between the host sequencer (master) and the ASCON core (slave).
interface ascon_host_ctrl_if;

    logic [127:0] eng_key_o;
    logic [127:0] eng_nonce_o;
    logic [63:0]  eng_data_o;
    logic         eng_start_o;
    logic         eng_data_valid_o;
    logic [63:0]  eng_cipher_i;
    logic         eng_cipher_valid_i;
    logic         eng_end_i;
    logic [127:0] eng_tag_i;

    modport master (
        output eng_key_o, eng_nonce_o, eng_data_o, eng_start_o, eng_data_valid_o,
        input  eng_cipher_i, eng_cipher_valid_i, eng_end_i, eng_tag_i
    );

    modport slave (
        input  eng_key_o, eng_nonce_o, eng_data_o, eng_start_o, eng_data_valid_o,
        output eng_cipher_i, eng_cipher_valid_i, eng_end_i, eng_tag_i
    );

endinterface

// File: rtl/ascon_host_ctrl_buffer.sv
// Plaintext register file: one write port, one combinational read port, async clear.
module ascon_host_buffer
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_addr_i,
    input  logic [63:0] wr_data_i,
    input  logic [1:0]  rd_idx_i,
    output logic [63:0] rd_data_o
);

    pt_buf_t mem;

    // Word write, whole array cleared on reset.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            mem <= '0;
        end else if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_idx_i];

endmodule

// File: rtl/ascon_host_ctrl.sv
// Host sequencer for the ASCON-128 core: replays start / AD / plaintext with fixed
// spacing, collects ciphertext words and the tag.
// Optional watchdog: define ASCON_HOST_TIMEOUT_EN.
module ascon_host_ctrl
    import ascon_pack::*;
#(
    parameter int unsigned NB_BLOCKS      = HOST_NB_BLOCKS,
    parameter int unsigned INIT_WAIT      = HOST_INIT_WAIT,
    parameter int unsigned BLOCK_WAIT     = HOST_BLOCK_WAIT,
    parameter int unsigned TIMEOUT_CYCLES = HOST_TIMEOUT_CYCLES
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic [127:0]  key_i,
    input  logic [127:0]  nonce_i,
    input  logic [63:0]   ad_i,
    input  logic          wr_en_i,
    input  logic [1:0]    wr_addr_i,
    input  logic [63:0]   wr_data_i,
    input  logic          go_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic          ct_valid_o,
    output logic [1:0]    ct_idx_o,
    output logic [63:0]   ct_data_o,
    output logic [127:0]  tag_o,
    ascon_host_ctrl_if.master eng
);

    host_state_t  state;
    logic [7:0]   wait_cnt;
    logic [1:0]   blk_cnt;
    logic         got_ct;
    logic [127:0] key_q;
    logic [127:0] nonce_q;
    logic [63:0]  ad_q;
    logic [63:0]  data_q;
    logic         start_q;
    logic         dv_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
    logic         ct_valid_q;
    logic [1:0]   ct_idx_q;
    logic [63:0]  ct_data_q;
    logic [127:0] tag_q;

    logic         buf_wr_en;
    logic [1:0]   rd_idx;
    logic [63:0]  rd_data;
    logic         cap;
    logic         waited;
    logic         last_blk;

`ifdef ASCON_HOST_TIMEOUT_EN
    logic [7:0]   tmo_cnt;
    logic         tmo_hit;
    assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0]  unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES;
`endif

    // Buffer writes are honoured only while idle.
    assign buf_wr_en = wr_en_i && (state == HOST_IDLE);

    // Read one word ahead in PT_WAIT so the next PT pulse carries buf[blk_cnt+1]
    // on the same edge that blk_cnt advances.
    always_comb begin
        rd_idx = blk_cnt;
        if (state == HOST_PT_WAIT) begin
            rd_idx = blk_cnt + 2'd1;
        end
    end

    // Capture / spacing qualifiers for PT_WAIT.
    always_comb begin
        cap      = eng.eng_cipher_valid_i && !got_ct;
        waited   = (wait_cnt >= 8'(BLOCK_WAIT - 1));
        last_blk = (blk_cnt == 2'(NB_BLOCKS - 1));
    end

    ascon_host_buffer u_buf (
        .clock_i   (clock_i),
        .resetb_i  (resetb_i),
        .wr_en_i   (buf_wr_en),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state      <= HOST_IDLE;
            wait_cnt   <= '0;
            blk_cnt    <= '0;
            got_ct     <= 1'b0;
            key_q      <= '0;
            nonce_q    <= '0;
            ad_q       <= '0;
            data_q     <= '0;
            start_q    <= 1'b0;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ct_valid_q <= 1'b0;
            ct_idx_q   <= '0;
            ct_data_q  <= '0;
            tag_q      <= '0;
`ifdef ASCON_HOST_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            ct_valid_q <= 1'b0;
            case (state)
                HOST_IDLE: begin
                    if (go_i) begin
                        key_q    <= key_i;
                        nonce_q  <= nonce_i;
                        ad_q     <= ad_i;
                        blk_cnt  <= '0;
                        tag_q    <= '0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        start_q  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= HOST_START;
                    end
                end
                HOST_START: begin
                    if (wait_cnt == 8'(INIT_WAIT - 1)) begin
                        start_q <= 1'b0;
                        dv_q    <= 1'b1;
                        data_q  <= ad_q;
                        state   <= HOST_AD;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOST_AD: begin
                    dv_q     <= 1'b0;
                    wait_cnt <= '0;
                    state    <= HOST_AD_WAIT;
                end
                HOST_AD_WAIT: begin
                    if (wait_cnt == 8'(BLOCK_WAIT - 1)) begin
                        dv_q   <= 1'b1;
                        data_q <= rd_data;
                        state  <= HOST_PT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOST_PT: begin
                    dv_q     <= 1'b0;
                    wait_cnt <= '0;
                    got_ct   <= 1'b0;
`ifdef ASCON_HOST_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                    state    <= HOST_PT_WAIT;
                end
                HOST_PT_WAIT: begin
                    if (cap) begin
                        ct_valid_q <= 1'b1;
                        ct_idx_q   <= blk_cnt;
                        ct_data_q  <= eng.eng_cipher_i;
                        got_ct     <= 1'b1;
                    end
                    if (!waited) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                    if ((got_ct || cap) && waited) begin
                        if (last_blk) begin
`ifdef ASCON_HOST_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                            state   <= HOST_END_WAIT;
                        end else begin
                            blk_cnt <= blk_cnt + 2'd1;
                            dv_q    <= 1'b1;
                            data_q  <= rd_data;
                            state   <= HOST_PT;
                        end
                    end
`ifdef ASCON_HOST_TIMEOUT_EN
                    else if (!(got_ct || cap)) begin
                        if (tmo_hit) begin
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= HOST_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
`endif
                end
                HOST_END_WAIT: begin
                    if (eng.eng_end_i) begin
                        tag_q  <= eng.eng_tag_i;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= HOST_IDLE;
                    end
`ifdef ASCON_HOST_TIMEOUT_EN
                    else if (tmo_hit) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= HOST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                default: state <= HOST_IDLE;
            endcase
        end
    end

    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign error_o              = err_q;
    assign ct_valid_o           = ct_valid_q;
    assign ct_idx_o             = ct_idx_q;
    assign ct_data_o            = ct_data_q;
    assign tag_o                = tag_q;
    assign eng.eng_key_o        = key_q;
    assign eng.eng_nonce_o      = nonce_q;
    assign eng.eng_data_o       = data_q;
    assign eng.eng_start_o      = start_q;
    assign eng.eng_data_valid_o = dv_q;

endmodule

// File: tb/tb_ascon_host_ctrl.sv
// Directed bench for ascon_host_ctrl with a behavioural engine responder.
// Edge numbers are relative to the edge that accepts go_i.
module tb_ascon_host_ctrl;

    localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] NONCE = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [63:0]  AD    = 64'h3230323380000000;
    localparam logic [63:0]  MASK  = 64'hA5A55A5A0F0FF0F0;
    localparam logic [127:0] TAG   = 128'hC0FFEE00112233445566778899ABCDEF;

    logic [63:0] pt [4];

    logic          clock = 1'b0;
    logic          resetb;
    logic [127:0]  key, nonce;
    logic [63:0]   ad;
    logic          wr_en, go;
    logic [1:0]    wr_addr;
    logic [63:0]   wr_data;
    logic          busy, done, error, ct_valid;
    logic [1:0]    ct_idx_o;
    logic [63:0]   ct_data_o;
    logic [127:0]  tag;

    ascon_host_ctrl_if eng ();

    ascon_host_ctrl dut (
        .clock_i    (clock),
        .resetb_i   (resetb),
        .key_i      (key),
        .nonce_i    (nonce),
        .ad_i       (ad),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .go_i       (go),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .ct_valid_o (ct_valid),
        .ct_idx_o   (ct_idx_o),
        .ct_data_o  (ct_data_o),
        .tag_o      (tag),
        .eng        (eng.master)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag_s, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag_s, got, exp);
        end
    endtask

    // Engine configuration (written only by the main process).
    int go_edge = 0;
    int lat     = 3;
    int end_off = 12;
    int end_len = 1;
    bit end_en  = 1'b1;

    // Engine responder / monitor logs (written only by the engine process).
    int          ev;
    int          cv_at = -1, end_at = -1;
    logic [63:0] cv_val;
    bit          prev_start = 1'b0;
    int          start_first, start_cnt;
    int          dv_n, ct_n, done_n, done_edge;
    bit          busy_at_done;
    int          dv_edge [8];
    logic [63:0] dv_data [8];
    int          ct_edge [8];
    logic [1:0]  ct_idx  [8];
    logic [63:0] ct_dat  [8];

    always @(negedge clock) begin
        ev = cyc + 1 - go_edge;
        eng.eng_cipher_valid_i = 1'b0;
        eng.eng_end_i          = 1'b0;
        eng.eng_tag_i          = TAG;
        if (!resetb) begin
            cv_at  = -1;
            end_at = -1;
        end
        if (ev == cv_at) begin
            eng.eng_cipher_valid_i = 1'b1;
            eng.eng_cipher_i       = cv_val;
        end
        if (end_at >= 0 && ev >= end_at && ev < end_at + end_len)
            eng.eng_end_i = 1'b1;
        if (eng.eng_start_o && !prev_start) begin
            start_first = ev;
            start_cnt = 0; dv_n = 0; ct_n = 0; done_n = 0; done_edge = -1;
            cv_at = -1; end_at = -1;
        end
        if (eng.eng_start_o) start_cnt++;
        prev_start = eng.eng_start_o;
        if (eng.eng_data_valid_o && dv_n < 8) begin
            dv_edge[dv_n] = ev;
            dv_data[dv_n] = eng.eng_data_o;
            if (dv_n > 0) begin
                cv_at  = ev + lat;
                cv_val = eng.eng_data_o ^ MASK;
                if (dv_n == 4 && end_en) end_at = cv_at + end_off;
            end
            dv_n++;
        end
        if (ct_valid && ct_n < 8) begin
            ct_edge[ct_n] = ev;
            ct_idx[ct_n]  = ct_idx_o;
            ct_dat[ct_n]  = ct_data_o;
            ct_n++;
        end
        if (done) begin
            done_n++;
            done_edge    = ev;
            busy_at_done = busy;
        end
    end

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic fire();
        key = KEY; nonce = NONCE; ad = AD;
        go = 1'b1;
        go_edge = cyc + 1;
        @(negedge clock);
        go = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc + 1 - go_edge < n) @(negedge clock);
    endtask

    task automatic load_buf();
        for (int unsigned i = 0; i < 4; i++) wr(2'(i), pt[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_dv [5];
        exp_dv = '{19, 30, 41, 52, 63};
        pt[0] = 64'h436F6E636576657A;
        pt[1] = 64'h204153434F4E2065;
        pt[2] = 64'h6E2053797374656D;
        pt[3] = 64'h566572696C6F6780;
        resetb = 1'b0; key = '0; nonce = '0; ad = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
        eng.eng_cipher_i = '0; eng.eng_cipher_valid_i = 1'b0;
        eng.eng_end_i = 1'b0; eng.eng_tag_i = TAG;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_ct_valid", ct_valid, 0);
        chk("rst_tag", tag, 0);
        chk("rst_start", eng.eng_start_o, 0);
        chk("rst_dv", eng.eng_data_valid_o, 0);
        chk("rst_key", eng.eng_key_o, 0);
        resetb = 1'b1;
        @(negedge clock);

        // Run 1: protocol replay, cipher latency 3.
        load_buf();
        lat = 3; end_off = 12; end_len = 1; end_en = 1'b1;
        fire();
        wait_rel(90);
        chk("r1_start_first", start_first, 1);
        chk("r1_start_width", start_cnt, 18);
        chk("r1_dv_count", dv_n, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("r1_dv_edge%0d", i), dv_edge[i], exp_dv[i]);
        chk("r1_dv_ad", dv_data[0], AD);
        for (int i = 0; i < 4; i++) chk($sformatf("r1_dv_pt%0d", i), dv_data[i+1], pt[i]);
        chk("r1_ct_count", ct_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("r1_ct_idx%0d", i), ct_idx[i], i);
            chk($sformatf("r1_ct_data%0d", i), ct_dat[i], pt[i] ^ MASK);
            chk($sformatf("r1_ct_edge%0d", i), ct_edge[i], exp_dv[i+1] + 3 + 1);
        end
        chk("r1_done_count", done_n, 1);
        chk("r1_done_edge", done_edge, 79);
        chk("r1_busy_at_done", busy_at_done, 0);
        chk("r1_tag", tag, TAG);
        chk("r1_key", eng.eng_key_o, KEY);
        chk("r1_nonce", eng.eng_nonce_o, NONCE);

        // Run 2: busy lockout plus cipher/end coinciding on the last block.
        lat = 10; end_off = 0; end_len = 2;
        fire();
        wait_rel(25);
        go = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 64'hDEADBEEFDEADBEEF;
        key = ~KEY;
        @(negedge clock);
        go = 1'b0; wr_en = 1'b0; key = KEY;
        wait_rel(90);
        chk("r2_start_first", start_first, 1);
        chk("r2_start_width", start_cnt, 18);
        chk("r2_dv_count", dv_n, 5);
        chk("r2_dv_last_edge", dv_edge[4], 63);
        chk("r2_buf_unchanged", dv_data[2], pt[1]);
        chk("r2_key_kept", eng.eng_key_o, KEY);
        chk("r2_ct_count", ct_n, 4);
        chk("r2_ct3_data", ct_dat[3], pt[3] ^ MASK);
        chk("r2_done_count", done_n, 1);
        chk("r2_done_edge", done_edge, 75);

        // Run 3: reset during PT_WAIT of block 2, then restart from a cleared buffer.
        lat = 3; end_off = 12; end_len = 1;
        fire();
        wait_rel(56);
        resetb = 1'b0;
        @(negedge clock);
        chk("r3_busy", busy, 0);
        chk("r3_ct_data", ct_data_o, 0);
        chk("r3_tag", tag, 0);
        chk("r3_dv", eng.eng_data_valid_o, 0);
        chk("r3_data", eng.eng_data_o, 0);
        chk("r3_key", eng.eng_key_o, 0);
        chk("r3_nonce", eng.eng_nonce_o, 0);
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        fire();
        wait_rel(90);
        chk("r3b_start_first", start_first, 1);
        chk("r3b_start_width", start_cnt, 18);
        chk("r3b_buf_cleared", dv_data[1], 0);
        chk("r3b_ct0", ct_dat[0], MASK);
        chk("r3b_done_edge", done_edge, 79);
        chk("r3b_tag", tag, TAG);

        // Run 4: cipher delayed 15 cycles.
        load_buf();
        lat = 15; end_off = 5;
        fire();
        wait_rel(110);
        chk("r4_dv_edge1", dv_edge[1], 30);
        chk("r4_dv_edge2", dv_edge[2], 46);
        chk("r4_dv_edge3", dv_edge[3], 62);
        chk("r4_dv_edge4", dv_edge[4], 78);
        chk("r4_ct3", ct_dat[3], pt[3] ^ MASK);
        chk("r4_done_edge", done_edge, 99);

        // Run 5: engine never raises end.
        lat = 3; end_en = 1'b0;
        fire();
`ifdef ASCON_HOST_TIMEOUT_EN
        wait_rel(137);
        chk("r5_error_before", error, 0);
        chk("r5_busy_before", busy, 1);
        wait_rel(138);
        chk("r5_error", error, 1);
        chk("r5_busy", busy, 0);
        chk("r5_done_count", done_n, 0);
`else
        wait_rel(200);
        chk("r5_busy_waiting", busy, 1);
        chk("r5_error", error, 0);
        chk("r5_done_count", done_n, 0);
`endif
        resetb = 1'b0;
        @(negedge clock);
        chk("r5_rst_busy", busy, 0);
        resetb = 1'b1;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascon_host_ctrl.md
# ascon_host_ctrl

Host-side sequencer that drives the `top_level` ASCON-128 encryption core from the initiator end of its start/data_valid interface. It holds key, nonce, one associated-data word and a four-word plaintext buffer. On a single `go_i` pulse it replays the core's input protocol with fixed inter-word spacing. It collects each ciphertext word and the final tag and presents them to the host with a done flag.

## Interface
- `NB_BLOCKS`, 4: plaintext words per message; last word is pre-padded by the host.
- `INIT_WAIT`, 18: cycles `eng_start_o` is held high.
- `BLOCK_WAIT`, 10: idle cycles after each `eng_data_valid_o` pulse before the next.
- `TIMEOUT_CYCLES`, 64: watchdog limit; used only with the macro.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock_i`  in  1  clock.
- `resetb_i`  in  1  asynchronous active-low reset.
- `key_i`  in  128  key; sampled on accepted `go_i`.
- `nonce_i`  in  128  nonce; sampled on accepted `go_i`.
- `ad_i`  in  64  padded associated-data word; sampled on accepted `go_i`.
- `wr_en_i`  in  1  plaintext buffer write strobe.
- `wr_addr_i`  in  2  buffer word index.
- `wr_data_i`  in  64  plaintext word.
- `go_i`  in  1  start request.
- `busy_o`  out  1  high from accepted `go_i` until return to IDLE.
- `done_o`  out  1  one-cycle pulse when the tag is captured.
- `error_o`  out  1  watchdog abort flag.
- `ct_valid_o`  out  1  one-cycle pulse per captured ciphertext word.
- `ct_idx_o`  out  2  index of that word.
- `ct_data_o`  out  64  ciphertext word.
- `tag_o`  out  128  captured tag; held until next accepted `go_i`.
- `eng_key_o`, `eng_nonce_o`  out  128 each  registered key and nonce to the core.
- `eng_data_o`  out  64  AD or plaintext word to the core.
- `eng_start_o`  out  1  core `start_i`.
- `eng_data_valid_o`  out  1  core `data_valid_i`.
- `eng_cipher_i`  in  64  core `cipher_o`.
- `eng_cipher_valid_i`  in  1  core `cipher_valid_o`.
- `eng_end_i`  in  1  core `end_o`.
- `eng_tag_i`  in  128  core `tag_o`.

## Operation
- **Writes:** honoured only in IDLE; ignored while `busy_o` is high. `go_i` is also ignored while busy.
- **FSM states:** IDLE, START, AD, AD_WAIT, PT, PT_WAIT, END_WAIT.
- **IDLE → START:** on `go_i`. Latch key, nonce and AD; clear `blk_cnt`, `tag_o` and `error_o`.
- **START:** `eng_start_o`=1 for `INIT_WAIT` cycles, then → AD.
- **AD:** `eng_data_o`=AD and `eng_data_valid_o`=1 for exactly 1 cycle, then → AD_WAIT.
- **AD_WAIT:** `BLOCK_WAIT` idle cycles, then → PT.
- **PT:** `eng_data_o`=buf[`blk_cnt`] and `eng_data_valid_o`=1 for 1 cycle, then → PT_WAIT.
- **PT_WAIT:** on `eng_cipher_valid_i`, capture `eng_cipher_i` and pulse `ct_valid_o` with `ct_idx_o`=`blk_cnt`. Leave the state only when a word has been captured and `BLOCK_WAIT` cycles have elapsed, whichever is later.
  - If `blk_cnt`=`NB_BLOCKS`-1 → END_WAIT.
  - Otherwise increment `blk_cnt` → PT.
- **END_WAIT:** on `eng_end_i`, latch `eng_tag_i` into `tag_o`, pulse `done_o`, → IDLE.
- **Ignored engine events:** `eng_cipher_valid_i` outside PT_WAIT, or a second one within a PT_WAIT, is ignored. `eng_end_i` outside END_WAIT is ignored.
- **Simultaneous events:** `eng_cipher_valid_i` and `eng_end_i` together on the last block: capture the ciphertext, go to END_WAIT, and take `end` on the next cycle if it is still high. Otherwise wait.
- **Reset (including mid-operation):** FSM → IDLE; buffer, key, nonce, AD and `tag_o` cleared to 0; all outputs 0.

## Timing
- **Engine-side pulse schedule**, with accepted `go_i` at edge 0:
  - `eng_start_o` high edges 1–18.
  - AD `eng_data_valid_o` at edge 19.
  - P1 at edge 30; P2–P4 every 11 edges thereafter, provided each ciphertext arrives within 10 cycles.
- `ct_valid_o` follows `eng_cipher_valid_i` by 1 cycle.
- `done_o` follows `eng_end_i` by 1 cycle.
- `busy_o` falls on the same edge `done_o` rises.

## Configuration
- **`ASCON_HOST_TIMEOUT_EN` defined:**
  - A counter runs in PT_WAIT (until the word is captured) and in END_WAIT.
  - Reaching `TIMEOUT_CYCLES` sets `error_o`=1, which holds until the next accepted `go_i`. The FSM → IDLE with no `done_o`.
- **Undefined:** no counter; waits indefinitely; `error_o` tied 0.

## Structure
- `ascon_pack` gains:
  - the `host_state_t` enum;
  - the constants `HOST_INIT_WAIT`=18 and `HOST_BLOCK_WAIT`=10;
  - a `pt_buf_t` typedef for the 4×64 array.
- One sub-module, `ascon_host_buffer`: a 4×64 register file with write port, one combinational read port indexed by `blk_cnt`, and asynchronous clear.

## Test plan
- **Protocol replay:**
  - Stimulus: key 000102030405060708090A0B0C0D0E0F, nonce 00112233445566778899AABBCCDDEEFF, AD 3230323380000000, buffer 436F6E636576657A / 204153434F4E2065 / 6E2053797374656D / 566572696C6F6780.
  - Response: `eng_start_o` is 18 cycles wide; `data_valid` pulses at edges 19, 30, 41, 52, 63.
- **End-to-end with `top_level` attached:**
  - Four `ct_valid_o` pulses, idx 0–3, with `ct_data_o` equal to the core's `cipher_o`.
  - `done_o` once; `tag_o` equal to `eng_tag_i`.
- **Busy lockout:**
  - `go_i` and `wr_en_i` asserted mid-run → no restart, buffer unchanged.
- **Reset mid-run:**
  - `resetb_i`=0 during PT_WAIT of block 2 → all outputs 0 and IDLE.
  - A new `go_i` after release restarts at START.
- **Delayed cipher:**
  - Core cipher delayed 15 cycles → next PT pulse 1 cycle after capture, not at 10 cycles.
- **Timeout (`ASCON_HOST_TIMEOUT_EN`):**
  - `eng_end_i` never asserted → `error_o`=1 after 64 cycles in END_WAIT, `busy_o`=0, `done_o` never pulses.
